// File: rtl/e_mdu_if.sv
// Operand/result bundle between the E-stage control path and the multiply/divide unit.
// The master side issues operations; the slave side reports busy and the HI/LO registers.
interface e_mdu_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdop, a, b, input busy, hi, lo);
    modport slave  (input start, mdop, a, b, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Results come from operands latched at accept time and land on hi/lo on the completion edge.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  mdu
);
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int          CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               uns_q, uns_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    // Multiply: a 64-bit product of suitably extended operands is correct for both signednesses.
    logic [63:0] ext_a, ext_b, prod;
    assign ext_a = uns_q ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
    assign ext_b = uns_q ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // Divide on magnitudes, then restore signs; divisor forced non-zero since b=0 never commits.
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, dvs, q_mag, r_mag, quot, rem;
    assign neg_a = !uns_q && a_q[31];
    assign neg_b = !uns_q && b_q[31];
    assign mag_a = neg_a ? (~a_q + 32'd1) : a_q;
    assign mag_b = neg_b ? (~b_q + 32'd1) : b_q;
    assign dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag = mag_a / dvs;
    assign r_mag = mag_a % dvs;
    assign quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        uns_d   = uns_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    case (mdu.mdop)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            a_d     = mdu.a;
                            b_d     = mdu.b;
                            uns_d   = mdu.mdop[0];
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            a_d     = mdu.a;
                            b_d     = mdu.b;
                            uns_d   = mdu.mdop[0];
                        end
                        OP_MTHI: hi_d = mdu.a;
                        OP_MTLO: lo_d = mdu.a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end
            end
            S_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            uns_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            uns_q   <= uns_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu.busy = (state_q != S_IDLE);
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Randomised self-checking bench for e_mdu against an arithmetic reference model.
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    e_mdu_if mdu ();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: what an op does to HI/LO and how many cycles it keeps the unit busy.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        longint      p, q, r;
        logic [63:0] pu;
        lat = 0;
        case (op)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                exp_hi = p[63:32]; exp_lo = p[31:0]; lat = MC;
            end
            3'd1: begin
                pu = {32'd0, x} * {32'd0, y};
                exp_hi = pu[63:32]; exp_lo = pu[31:0]; lat = MC;
            end
            3'd2: begin
                if (y != 0) begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    exp_lo = q[31:0]; exp_hi = r[31:0];
                end
                lat = DC;
            end
            3'd3: begin
                if (y != 0) begin
                    exp_lo = x / y; exp_hi = x % y;
                end
                lat = DC;
            end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            default: ;
        endcase
    endtask

    // Entered and left at a falling edge with start low.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit toggle, input bit collide);
        logic [31:0] old_hi, old_lo;
        int lat;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, x, y, lat);
        mdu.start = 1'b1; mdu.mdop = op; mdu.a = x; mdu.b = y;
        @(negedge clk);
        mdu.start = 1'b0;
        for (int k = 0; k < lat; k++) begin
            check_val("busy_hi", {31'd0, mdu.busy}, 32'd1);
            check_val("hold_hi", mdu.hi, old_hi);
            check_val("hold_lo", mdu.lo, old_lo);
            if (toggle) begin
                mdu.a = $urandom; mdu.b = $urandom;
            end
            mdu.start = collide && (k == 2);
            if (collide && (k == 2)) begin
                mdu.mdop = 3'd0; mdu.a = $urandom; mdu.b = $urandom;
            end
            @(negedge clk);
        end
        mdu.start = 1'b0;
        check_val("busy_lo", {31'd0, mdu.busy}, 32'd0);
        check_val("res_hi", mdu.hi, exp_hi);
        check_val("res_lo", mdu.lo, exp_lo);
        $display("op=%0d a=%h b=%h lat=%0d -> hi=%h lo=%h", op, x, y, lat, mdu.hi, mdu.lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: pick_operand = 32'd0;
            1: pick_operand = 32'h8000_0000;
            2: pick_operand = 32'hFFFF_FFFF;
            3: pick_operand = 32'd1;
            default: pick_operand = $urandom;
        endcase
    endfunction

    initial begin
        n_checks = 0; n_fail = 0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        reset = 1'b0;
        mdu.start = 1'b0; mdu.mdop = 3'd0; mdu.a = 32'd0; mdu.b = 32'd0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, mdu.busy}, 32'd0);
        check_val("rst_hi", mdu.hi, 32'd0);
        check_val("rst_lo", mdu.lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
        check_val("mult_neg_hi", mdu.hi, 32'hFFFF_FFFF);
        check_val("mult_neg_lo", mdu.lo, 32'hFFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
        check_val("multu_hi", mdu.hi, 32'h0000_0001);
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        check_val("div_m7_lo", mdu.lo, 32'hFFFF_FFFD);
        check_val("div_m7_hi", mdu.hi, 32'hFFFF_FFFF);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_val("div_ovf_lo", mdu.lo, 32'h8000_0000);
        check_val("div_ovf_hi", mdu.hi, 32'h0000_0000);
        do_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        do_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        do_op(3'd3, 32'h0000_0005, 32'd0, 1'b1, 1'b0);
        check_val("divz_hi", mdu.hi, 32'h1234_5678);
        check_val("divz_lo", mdu.lo, 32'h9ABC_DEF0);

        // Asynchronous reset in the fourth busy cycle of a divide.
        mdu.start = 1'b1; mdu.mdop = 3'd2; mdu.a = 32'd100; mdu.b = 32'd7;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_abort_busy", {31'd0, mdu.busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("abort_busy", {31'd0, mdu.busy}, 32'd0);
        check_val("abort_hi", mdu.hi, 32'd0);
        check_val("abort_lo", mdu.lo, 32'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        $display("async reset during div -> hi=%h lo=%h busy=%0d", mdu.hi, mdu.lo, mdu.busy);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(3'd0, 32'h0001_0003, 32'hFFFF_FFFD, 1'b0, 1'b0);

        // Start while busy must be ignored.
        do_op(3'd2, 32'd1000, 32'hFFFF_FFF9, 1'b0, 1'b1);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0);
        do_op(3'd7, 32'hCAFE_F00D, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes mult, multu, div, divu, mthi and mtlo on forwarded rs/rt operands and holds the HI/LO architectural registers. mfhi and mflo read HI/LO combinationally and carry the value into the E→M pipeline register. A `busy` indication feeds StallControl, which holds D while an MD-class instruction is in D and the unit is `busy` or being started.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  qualifies mdop/a/b this cycle; driven by E_CU for MD-class instructions
- mdop  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 no-op
- a  input  32  forwarded rs value (E_MFRD1)
- b  input  32  forwarded rt value (E_MFRD2)
- busy  output  1  multi-cycle operation in progress
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- State machine: IDLE, MUL, DIV.
  - IDLE→MUL on `start`, mdop 0/1.
  - IDLE→DIV on `start`, mdop 2/3.
  - MUL or DIV→IDLE when the down-counter reaches 0.
- Capture: on accept, latch a, b, op and a counter preload (MULT_CYCLES or DIV_CYCLES). The result is computed from the latched copies, so later changes on a/b have no effect.
- mult: {hi,lo} = signed 64-bit a×b. multu: unsigned 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (b=0, div or divu): the full DIV_CYCLES latency is observed; hi and lo are left unchanged.
- mthi: hi←a at the next edge. mtlo: lo←a at the next edge. Neither asserts `busy`. Both are single-cycle and accepted only in IDLE.
- `start` while `busy`=1 is ignored; StallControl guarantees this does not occur. mdop 6–7 with `start` is ignored.
- hi and lo change only on mthi/mtlo or on the completion edge. Intermediate iterative-divider state is never visible on hi/lo.
- Implementation choice is open: iterative shift-subtract, or a combinational result held in a pending register. The only requirement is cycle-exact external behaviour.

## Timing
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, state IDLE, counter 0. A reset asserted mid-operation aborts it and the result is discarded. Operation resumes at the first rising edge after reset=1.
- `busy` is registered, with no combinational path from start to busy. StallControl forms its stall term as (start | busy).
- Example with start accepted at edge t and N = MULT_CYCLES or DIV_CYCLES:
  - busy=1 after edges t … t+N−1, i.e. exactly N cycles.
  - At edge t+N: busy←0 and hi/lo←result together.
- Back-to-back: a new `start` is accepted in the first cycle with busy=0, i.e. sampled at edge t+N+1 at the earliest. An mfhi issued then sees the new value.
- mthi/mtlo latency: 1 edge. An mfhi in the following cycle reads the written value.

## Test plan
- mult with a=0xFFFFFFFF, b=0x00000002 → busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE on the same edge busy falls; hi/lo unchanged before that edge.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles; a/b toggled during busy has no effect on the result.
- div with a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; also 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi with a=0x12345678, then mtlo with a=0x9ABCDEF0 on consecutive cycles → hi, then lo, update one edge after each; busy stays 0; then divu by b=0 → busy 10 cycles, hi/lo unchanged.
- Start div, drop reset to 0 at cycle 4 of busy → hi=lo=0 and busy=0 immediately (asynchronous); after release, a mult accepted normally with a 5-cycle latency.
- start asserted with mult while busy from an earlier div → ignored; the div result and timing are unaffected.
